// File: rtl/load_store_unit_pkg.sv
// Shared types, encodings and lane helpers for the memory-stage load/store unit.
package load_store_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  // Access size encodings as presented by decode.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Completion status reported alongside done.
  typedef enum logic [1:0] {
    FLT_OK       = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_TIMEOUT  = 2'b10,
    FLT_SIZE     = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Data-memory request payload, held stable for the whole REQ phase.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } mem_bus_t;

  // Operand fields needed after the request phase to format the result.
  typedef struct packed {
    logic [1:0] addr_lo;
    size_e      size;
    logic       is_unsigned;
    logic       is_store;
  } op_t;

  // Illegal size wins over misalignment.
  function automatic fault_e lsu_fault(input logic [1:0] size, input logic [1:0] addr_lo);
    fault_e f;
    f = FLT_OK;
    if (size == SZ_ILL) begin
      f = FLT_SIZE;
    end else if ((size == SZ_HALF) && addr_lo[0]) begin
      f = FLT_MISALIGN;
    end else if ((size == SZ_WORD) && (addr_lo != 2'b00)) begin
      f = FLT_MISALIGN;
    end
    return f;
  endfunction

  // Little-endian byte enables for an aligned access.
  function automatic logic [BE_W-1:0] lsu_be(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [BE_W-1:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate store data across every lane so any byte enable sees the right value.
  function automatic logic [XLEN-1:0] lsu_wdata(input logic [1:0] size, input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align_ext.sv
// Load data path: select the addressed lane from the memory word and extend it to XLEN.
module load_align_ext
  import load_store_unit_pkg::*;
(
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [1:0]      size_i,
  input  logic            is_unsigned_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] lane;
  logic            sign_b;
  logic            sign_h;

  assign lane   = mem_rdata_i >> {addr_lo_i, 3'b000};
  assign sign_b = ~is_unsigned_i & lane[7];
  assign sign_h = ~is_unsigned_i & lane[15];

  // Extend from bit 7 or bit 15; word loads pass straight through.
  always_comb begin
    rdata_o = '0;
    case (size_i)
      SZ_BYTE: rdata_o = {{(XLEN - 8){sign_b}}, lane[7:0]};
      SZ_HALF: rdata_o = {{(XLEN - 16){sign_h}}, lane[15:0]};
      SZ_WORD: rdata_o = lane;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: latches the ALU effective address and store data,
// drives a req/ack data-memory port, formats load results and reports faults.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            is_store,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rdata_out,
  output logic [1:0]      fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t             op_q, op_d;
  mem_bus_t        bus_q, bus_d;
  logic            mem_req_q, mem_req_d;
  logic            done_q, done_d;
  fault_e          fault_q, fault_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  fault_e          start_fault;
  logic [XLEN-1:0] load_data;

  assign start_fault = lsu_fault(size, addr[1:0]);

  load_align_ext u_align (
    .mem_rdata_i   (mem_rdata),
    .addr_lo_i     (op_q.addr_lo),
    .size_i        (op_q.size),
    .is_unsigned_i (op_q.is_unsigned),
    .rdata_o       (load_data)
  );

  // Stall while an access is being issued or is outstanding; released in DONE.
  assign busy = (start && (state_q != ST_REQ)) || (state_q == ST_REQ);

  assign done      = done_q;
  assign rdata_out = rdata_q;
  assign fault     = fault_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = bus_q.we;
  assign mem_addr  = bus_q.addr;
  assign mem_be    = bus_q.be;
  assign mem_wdata = bus_q.wdata;

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      bus_q     <= '0;
      mem_req_q <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= FLT_OK;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      bus_q     <= bus_d;
      mem_req_q <= mem_req_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    bus_d     = bus_q;
    mem_req_d = mem_req_q;
    done_d    = 1'b0;
    fault_d   = fault_q;
    rdata_d   = rdata_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        if (start) begin
          op_d.addr_lo     = addr[1:0];
          op_d.size        = size_e'(size);
          op_d.is_unsigned = is_unsigned;
          op_d.is_store    = is_store;
          if (start_fault != FLT_OK) begin
            // Faulting access never reaches memory; report it straight away.
            state_d = ST_DONE;
            done_d  = 1'b1;
            fault_d = start_fault;
            rdata_d = '0;
          end else begin
            state_d     = ST_REQ;
            mem_req_d   = 1'b1;
            cnt_d       = '0;
            bus_d.we    = is_store;
            bus_d.addr  = {addr[XLEN-1:2], 2'b00};
            bus_d.be    = lsu_be(size, addr[1:0]);
            bus_d.wdata = lsu_wdata(size, wdata);
          end
        end
      end

      ST_REQ: begin
        if (mem_ack) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          bus_d.we  = 1'b0;
          done_d    = 1'b1;
          fault_d   = FLT_OK;
          rdata_d   = op_q.is_store ? '0 : load_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          bus_d.we  = 1'b0;
          done_d    = 1'b1;
          fault_d   = FLT_TIMEOUT;
          rdata_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

endmodule
